// File: rtl/uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter                                                            |
// | Round-robin, packet-locked arbiter sharing one uart_tx among N_SRC sources.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module uart_tx_arbiter #(
    parameter int N_SRC    = 4,
    parameter int Word_len = 8,
    parameter int clk_rate = 100000000,
    parameter int Baud     = 115200,
    parameter int GAP_BITS = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SRC*Word_len-1:0] s_data,
    input  logic [N_SRC-1:0]          s_valid,
    input  logic [N_SRC-1:0]          s_last,
    output logic [N_SRC-1:0]          s_ready,
    output logic [Word_len-1:0]       m_data,
    output logic                      m_valid,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic [$clog2(N_SRC)-1:0]  grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int c_BIT_CYC = clk_rate / Baud;
    localparam int c_GAP_CYC = GAP_BITS * c_BIT_CYC;
    localparam int c_IDW     = $clog2(N_SRC);
    localparam int c_GW      = (c_GAP_CYC > 0) ? $clog2(c_GAP_CYC + 1) : 1;
    localparam int c_TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [c_IDW-1:0] grant_q, grant_d;
    logic [c_IDW-1:0] rr_q, rr_d;
    logic [c_GW-1:0]  gap_q, gap_d;
    logic [c_TW-1:0]  to_q, to_d;
    logic             terr_q, terr_d;
    logic             busy_q;
    logic [c_IDW-1:0] pick;
    logic             pick_ok;

    // First requester strictly after the last-served source, wrapping.
    always_comb begin
        pick    = rr_q;
        pick_ok = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            int               idx;
            logic [c_IDW-1:0] cand;
            idx = int'(rr_q) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            cand = c_IDW'(idx);
            if (!pick_ok && s_valid[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        gap_d   = gap_q;
        to_d    = to_q;
        terr_d  = 1'b0;
        s_ready = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = s_data[int'(grant_q)*Word_len +: Word_len];

        case (state_q)
            S_IDLE: begin
                to_d  = '0;
                gap_d = '0;
                if (pick_ok) begin
                    grant_d = pick;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                m_valid          = s_valid[grant_q];
                m_last           = s_last[grant_q];
                s_ready[grant_q] = m_ready;
                if (m_valid && m_ready) begin
                    to_d = '0;
                    if (m_last) begin
                        rr_d    = grant_q;
                        state_d = S_DRAIN;
                    end
                end else if (!m_valid) begin
                    // Stall only counts while the owner has nothing to offer.
                    if (to_q == c_TW'(TIMEOUT - 1)) begin
                        terr_d  = 1'b1;
                        rr_d    = grant_q;
                        to_d    = '0;
                        state_d = S_DRAIN;
                    end else begin
                        to_d = to_q + c_TW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (m_ready) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (int'(gap_q) + 1 >= c_GAP_CYC) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + c_GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= c_IDW'(N_SRC - 1);
            gap_q   <= '0;
            to_q    <= '0;
            terr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
            terr_q  <= terr_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

`default_nettype wire
